aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_phase_cnt.sv | 43 ++++
 rtl/aes_round_ctrl.sv | 117 +++++++++++
 tb/tb_aes_round_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller: state encoding, round
// constants and the per-state output decode.
package aes_pkg;

    localparam logic [3:0] NUM_ROUNDS = 4'd10;
    localparam logic [3:0] LOAD_RND   = 4'h1;
    localparam logic [3:0] FLUSH_RND  = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    typedef struct packed {
        logic       accept;
        logic [3:0] rnd;
        logic       sb;
        logic       sr;
        logic       mc;
        logic       ar;
        logic       ks;
        logic       out_valid;
        logic       busy;
    } ctrl_out_t;

    // The last round skips MixColumns; everything else is flat per state.
    function automatic ctrl_out_t decode_outputs(state_e st, logic [3:0] rnd);
        ctrl_out_t o;
        o = '0;
        case (st)
            ST_LOAD: begin
                o.accept = 1'b1;
                o.rnd    = LOAD_RND;
                o.busy   = 1'b1;
            end
            ST_ROUND: begin
                o.rnd  = rnd;
                o.sb   = 1'b1;
                o.sr   = 1'b1;
                o.mc   = (rnd != NUM_ROUNDS);
                o.ar   = 1'b1;
                o.ks   = 1'b1;
                o.busy = 1'b1;
            end
            ST_FLUSH: begin
                o.rnd       = FLUSH_RND;
                o.out_valid = 1'b1;
                o.busy      = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/aes_phase_cnt.sv
// Modulo-N slot counter with synchronous clear; exposes the current and the
// next count so the parent can register outputs that depend on it.
module aes_phase_cnt #(
    parameter int N = 4,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_nxt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // ">=" rather than "==" so a corrupted count still folds back to zero.
    assign wrap_o = (cnt_q >= LAST);

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end

    // NOTE: non-blocking in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an N-way interleaved AES-128 datapath: LOAD, ten
// ROUND steps and FLUSH, each N cycles long, with fully registered outputs.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       abort,
    output logic       accept,
    output logic [3:0] rndNo,
    output logic       enbSB,
    output logic       enbSR,
    output logic       enbMC,
    output logic       enbAR,
    output logic       enbKS,
    output logic [2:0] blk_idx,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] LAST_PHASE = 3'(N - 1);

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [2:0] phase_q, phase_d;
    logic       phase_wrap;
    ctrl_out_t  out_q, out_d;
    logic       done_q, done_d;

    aes_phase_cnt #(.N(N), .W(3)) u_phase (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (state_d == ST_IDLE),
        .en_i      (state_q != ST_IDLE),
        .cnt_o     (phase_q),
        .cnt_nxt_o (phase_d),
        .wrap_o    (phase_wrap)
    );

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        if (abort) begin
            state_d = ST_IDLE;
            round_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    round_d = '0;
                    if (start)
                        state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    if (phase_wrap) begin
                        state_d = ST_ROUND;
                        round_d = 4'd1;
                    end
                end
                ST_ROUND: begin
                    if (phase_wrap) begin
                        if (round_q >= NUM_ROUNDS) begin
                            state_d = ST_FLUSH;
                            round_d = '0;
                        end else begin
                            round_d = round_q + 4'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (phase_wrap)
                        state_d = start ? ST_LOAD : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    round_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they land in flops.
    always_comb begin
        out_d  = decode_outputs(state_d, round_d);
        done_d = (state_d == ST_FLUSH) && (phase_d == LAST_PHASE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign accept    = out_q.accept;
    assign rndNo     = out_q.rnd;
    assign enbSB     = out_q.sb;
    assign enbSR     = out_q.sr;
    assign enbMC     = out_q.mc;
    assign enbAR     = out_q.ar;
    assign enbKS     = out_q.ks;
    assign out_valid = out_q.out_valid;
    assign busy      = out_q.busy;
    assign done      = done_q;
    assign blk_idx   = phase_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with N=4: full batch timing, back-to-back
// batches, abort, start/abort collision and asynchronous reset mid-batch.
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       rstn, start, abort;
    logic       accept, enbSB, enbSR, enbMC, enbAR, enbKS, out_valid, busy, done;
    logic [3:0] rndNo;
    logic [2:0] blk_idx;

    int errors = 0;
    int checks = 0;

    aes_round_ctrl #(.N(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .accept    (accept),
        .rndNo     (rndNo),
        .enbSB     (enbSB),
        .enbSR     (enbSR),
        .enbMC     (enbMC),
        .enbAR     (enbAR),
        .enbKS     (enbKS),
        .blk_idx   (blk_idx),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] observed();
        return {accept, rndNo, enbSB, enbSR, enbMC, enbAR, enbKS, blk_idx, out_valid, busy, done};
    endfunction

    // Packed layout: accept, rndNo, {SB,SR,MC,AR,KS}, blk_idx, out_valid, busy, done.
    function automatic logic [15:0] vec(input logic acc, input logic [3:0] rnd, input logic [4:0] en,
                                        input logic [2:0] idx, input logic ov, input logic bz,
                                        input logic dn);
        return {acc, rnd, en, idx, ov, bz, dn};
    endfunction

    // Expected outputs for cycle c after the start edge: 4 LOAD, 40 ROUND, 4 FLUSH.
    function automatic logic [15:0] batch_exp(input int c);
        logic [3:0] r;
        logic [2:0] idx;
        idx = 3'(c % 4);
        if (c < 4)
            return vec(1'b1, 4'd1, 5'b00000, idx, 1'b0, 1'b1, 1'b0);
        if (c < 44) begin
            r = 4'((c - 4) / 4 + 1);
            return vec(1'b0, r, {2'b11, (r != 4'd10), 2'b11}, idx, 1'b0, 1'b1, 1'b0);
        end
        return vec(1'b0, 4'hB, 5'b00000, idx, 1'b1, 1'b1, (idx == 3'd3));
    endfunction

    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #12;
        check("reset_outputs", observed(), 16'h0000);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_after_reset", observed(), 16'h0000);

        // Single batch with a one-cycle start pulse.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 48; c++) begin
            check($sformatf("batch1_c%0d", c), observed(), batch_exp(c));
            @(negedge clk);
        end
        check("idle_after_batch1", observed(), 16'h0000);

        // start held high: FLUSH phase 3 must be followed directly by LOAD.
        start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 48; c++) begin
            check($sformatf("batch2_c%0d", c), observed(), batch_exp(c));
            @(negedge clk);
        end
        check("b2b_load_idx0", observed(), vec(1'b1, 4'd1, 5'b00000, 3'd0, 1'b0, 1'b1, 1'b0));
        start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            check($sformatf("batch3_c%0d", c), observed(), batch_exp(c));
        end

        // Abort in round 5, phase 2.
        abort = 1'b1;
        @(negedge clk);
        check("abort_to_idle", observed(), 16'h0000);
        abort = 1'b0;
        @(negedge clk);
        check("idle_after_abort", observed(), 16'h0000);

        // Simultaneous start and abort in IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check("start_abort_idle", observed(), 16'h0000);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("still_idle", observed(), 16'h0000);

        // Asynchronous reset during round 7.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 29; c++) begin
            check($sformatf("batch4_c%0d", c), observed(), batch_exp(c));
            @(negedge clk);
        end
        check("round7_before_reset", observed(), batch_exp(29));
        #2 rstn = 1'b0;
        #1;
        check("async_reset_zero", observed(), 16'h0000);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("no_resume_%0d", i), observed(), 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
